fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Drain-side companion to the synchronous FIFO. It pops words through the FIFO's first-word-fall-through read port (`r_data`, `r_en`, `empty`) and presents them as an AXI-stream master (`tvalid`/`tready`/`tdata`/`tlast`). The output is buffered by a 2-entry skid stage, so the stream runs at full throughput with no combinational path from `m_tready` to `fifo_r_en`. It sits between a producer-filled FIFO and a downstream stream consumer, and adds optional fixed-length packet framing.

## Interface
- `DATA_WIDTH`, default 32: width of FIFO words and `m_tdata`.
- `PKT_LEN`, default 8: beats per packet, must be ≥1. Used only when framing is compiled in.
- `BEAT_W`, localparam = max(1, $clog2(PKT_LEN)): beat counter width.
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `rd_enable`, in, 1: allows the block to pop from the FIFO.
- `fifo_r_data`, in, DATA_WIDTH: FIFO head word, valid whenever `!fifo_empty`.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_r_en`, out, 1: pop strobe. One word is consumed per cycle it is high.
- `m_tdata`, out, DATA_WIDTH: stream data.
- `m_tvalid`, out, 1: stream valid.
- `m_tready`, in, 1: stream ready.
- `m_tlast`, out, 1: last beat of a packet.
- `busy`, out, 1: high when `state != IDLE` or the skid stage is non-empty.
- `pkt_count`, out, 16: packets delivered. Wraps modulo 2^16.

## Operation
- **Pop rule.** `fifo_r_en = pop_allowed && !fifo_empty && buf_cnt < 2`.
  - `pop_allowed` is 1 in ACTIVE and STOP, 0 in IDLE.
  - `fifo_r_en` is never high while `fifo_empty` is high.
- **Popped word.** It is written into the skid stage together with its tlast tag.
- **Skid stage.** 2-entry FIFO ordered by `buf_cnt` (0..2).
  - `m_tvalid = (buf_cnt != 0)`; the head entry drives `m_tdata`/`m_tlast`.
  - A handshake (`m_tvalid && m_tready`) removes the head.
  - A simultaneous push and pop leaves `buf_cnt` unchanged.
- **Beat counter `beat`, 0..PKT_LEN-1.**
  - Advances on every pop and wraps to 0 after PKT_LEN-1.
  - Tag = (`beat == PKT_LEN-1`). With PKT_LEN=1, every beat is last.
- **`pkt_count`** increments on each handshake with `m_tlast = 1`.
- **FSM states: IDLE, ACTIVE, STOP.**
  - IDLE → ACTIVE when `rd_enable = 1`.
  - ACTIVE → IDLE when `rd_enable = 0` and `beat == 0` (packet boundary).
  - ACTIVE → STOP when `rd_enable = 0` and `beat != 0`.
  - STOP keeps popping until the packet's last beat is popped, then goes to IDLE.
  - STOP → ACTIVE if `rd_enable` returns to 1.
- **FIFO empty mid-packet.** Popping pauses and `m_tvalid` drops once the skid stage drains. `beat` holds its value, and framing resumes exactly where it stopped.
- **Backpressure** (`m_tready = 0`): the stage fills to 2, then `fifo_r_en` stays 0. No beat is lost or duplicated.
- **Reset** (asynchronous, including mid-packet): all state is cleared and skid contents are discarded.

## Timing
- **Reset values:** `fifo_r_en` 0, `m_tvalid` 0, `m_tdata` 0, `m_tlast` 0, `busy` 0, `pkt_count` 0, `beat` 0, state IDLE.
- **Latency:** the cycle `fifo_r_en` is high (pop at edge N) is followed by `m_tvalid` at N+1 when the stage was empty. A word entering an empty FIFO at edge W therefore appears on `m_tvalid` at W+2.
- **Throughput:** 1 beat/cycle sustained with `m_tready = 1`, at steady-state `buf_cnt = 1`.
- **Stream rule:** `m_tdata`/`m_tlast` stay stable while `m_tvalid && !m_tready`.
- **Path rule:** `fifo_r_en` depends only on registered state and `fifo_empty`.

## Configuration
- **With `FIFO_AXIS_TLAST_EN` defined:** the beat counter, tlast tag, STOP state and `pkt_count` are compiled in, as described above.
- **Without it:**
  - `m_tlast` is tied 0 and `pkt_count` is tied 0.
  - The STOP state does not exist.
  - `rd_enable = 0` in ACTIVE goes to IDLE immediately; words already in the stage are still delivered.

## Structure
- **Package `fifo_rd_pkg`:** the `rd_state_e` enum (IDLE, ACTIVE, STOP) and the `PKT_CNT_W = 16` constant.
- **Sub-module `axis_skid_buffer`:** the 2-entry skid stage, parameterized on DATA_WIDTH+1 to carry the tlast tag. The top level holds the FSM, beat counter and `pkt_count`.

## Test plan
All scenarios use PKT_LEN=4, with `FIFO_AXIS_TLAST_EN` defined unless noted.
- **Reset:** assert `rst_n = 0` with `fifo_empty = 0` and `rd_enable = 1` → all outputs 0 and `fifo_r_en` 0 throughout reset.
- **Full-rate stream:** preload 0x10..0x17, `rd_enable = 1`, `m_tready = 1` → 8 back-to-back beats in order, `m_tlast` on 0x13 and 0x17, `pkt_count = 2`, first `m_tvalid` one cycle after the first `fifo_r_en`.
- **Backpressure:** preload 0x20..0x27, `m_tready` toggling 1,0,0,1… → the sequence is delivered exactly once and in order, and `fifo_r_en = 0` whenever `buf_cnt = 2`.
- **Mid-packet stop:** drop `rd_enable` after the 2nd pop of a packet, with 8 words queued → exactly 2 more pops, then IDLE; 4 words remain in the FIFO; `busy` falls after the last handshake. Without the macro, pops stop immediately.
- **Empty mid-packet:** feed 2 words, wait 5 cycles, feed 2 more → `m_tvalid` drops in the gap and `m_tlast` is asserted on the 4th word.
- **Reset mid-packet:** pulse `rst_n` after beat 2 → outputs 0 asynchronously; the next 4 words form one packet with `m_tlast` on the 4th, and `pkt_count` restarts from 0.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO-to-AXI-stream drain path.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STOP   = 2'd2
  } rd_state_e;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output stage: the head entry drives the stream, the tail entry absorbs
// the word popped while the consumer stalls, so the FIFO side never waits on tready.
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_s;

  assign pop_s     = (cnt_q != 2'd0) && pop_ready;
  assign head_data = head_q;
  assign count     = cnt_q;

  // Next-state of the two entries; the head is cleared when the stage drains.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = push_data;
        end else begin
          tail_d = push_data;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
        end else begin
          head_d = '0;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data;
        end else begin
          head_d = push_data;
        end
      end
      default: begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a first-word-fall-through FIFO into an AXI-stream master through a skid stage.
// Define FIFO_AXIS_TLAST_EN to compile in fixed-length packet framing (tlast, STOP, pkt_count).
module fifo_axis_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic [PKT_CNT_W-1:0]  pkt_count
);

  rd_state_e           state_q, state_d;
  logic [1:0]          buf_cnt_s;
  logic                pop_s;
  logic                tag_s;
  logic [DATA_WIDTH:0] head_s;

  // Pop gating uses only registered state and fifo_empty, never m_tready.
  assign pop_s     = (state_q != IDLE) && !fifo_empty && (buf_cnt_s != 2'd2);
  assign fifo_r_en = pop_s;
  assign m_tvalid  = (buf_cnt_s != 2'd0);
  assign m_tdata   = head_s[DATA_WIDTH-1:0];
  assign m_tlast   = head_s[DATA_WIDTH];
  assign busy      = (state_q != IDLE) || (buf_cnt_s != 2'd0);

  axis_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pop_s),
    .push_data({tag_s, fifo_r_data}),
    .pop_ready(m_tready),
    .head_data(head_s),
    .count    (buf_cnt_s)
  );

`ifdef FIFO_AXIS_TLAST_EN
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

  assign tag_s     = (beat_q == LAST_BEAT);
  assign pkt_count = pkt_count_q;

  // Beat position, packet counter and FSM next state; boundaries use the post-pop beat.
  always_comb begin
    if (pop_s) begin
      beat_d = (beat_q == LAST_BEAT) ? {BEAT_W{1'b0}} : beat_q + BEAT_W'(1);
    end else begin
      beat_d = beat_q;
    end
    if (m_tvalid && m_tready && head_s[DATA_WIDTH]) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end else begin
      pkt_count_d = pkt_count_q;
    end
    case (state_q)
      IDLE:    state_d = rd_enable ? ACTIVE : IDLE;
      ACTIVE: begin
        if (rd_enable) begin
          state_d = ACTIVE;
        end else if (beat_d == {BEAT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (rd_enable) begin
          state_d = ACTIVE;
        end else if (beat_d == {BEAT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  assign tag_s     = 1'b0;
  assign pkt_count = {PKT_CNT_W{1'b0}};

  // Without framing the reader simply follows rd_enable.
  always_comb begin
    case (state_q)
      IDLE:    state_d = rd_enable ? ACTIVE : IDLE;
      ACTIVE:  state_d = rd_enable ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end
`endif

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
`ifdef FIFO_AXIS_TLAST_EN
      beat_q      <= {BEAT_W{1'b0}};
      pkt_count_q <= {PKT_CNT_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
`ifdef FIFO_AXIS_TLAST_EN
      beat_q      <= beat_d;
      pkt_count_q <= pkt_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Self-checking bench: the bench plays the FIFO and keeps a queue-based model of
// the stream (pop gating, two-slot output queue, packet position), checked every cycle.
module tb_fifo_axis_reader;

  localparam int DW = 32;
  localparam int PL = 4;
`ifdef FIFO_AXIS_TLAST_EN
  localparam bit TL = 1'b1;
`else
  localparam bit TL = 1'b0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_enable = 1'b0;
  logic [DW-1:0] fifo_r_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_r_en;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          busy;
  logic [15:0]   pkt_count;

  fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .rd_enable(rd_enable),
    .fifo_r_data(fifo_r_data), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   got_q[$];
  int mode = M_IDLE;
  int pos = 0;
  int pkts = 0;
  int dut_pops = 0;
  logic s_ren, s_valid;

  // One clock cycle: present FIFO head, compare outputs with the model, advance model.
  task automatic cycle();
    logic          e_ren, e_valid, e_last, e_busy;
    logic [DW-1:0] e_data;
    logic [15:0]   e_pkt;
    logic [DW-1:0] w;
    @(negedge clk);
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = fifo_empty ? '0 : fifo_q[0];
    #1;
    if (!rst_n) begin
      mode = M_IDLE; pos = 0; pkts = 0; exp_q.delete();
    end
    e_ren   = rst_n && (mode != M_IDLE) && (fifo_q.size() > 0) && (exp_q.size() < 2);
    e_valid = (exp_q.size() > 0);
    e_data  = e_valid ? exp_q[0][DW-1:0] : '0;
    e_last  = e_valid ? exp_q[0][DW] : 1'b0;
    e_busy  = (mode != M_IDLE) || e_valid;
    e_pkt   = TL ? 16'(pkts) : 16'd0;
    checks += 4;
    if (fifo_r_en !== e_ren) begin
      errors++; $display("FAIL r_en t=%0t got %b exp %b", $time, fifo_r_en, e_ren);
    end
    if (m_tvalid !== e_valid) begin
      errors++; $display("FAIL tvalid t=%0t got %b exp %b", $time, m_tvalid, e_valid);
    end
    if (busy !== e_busy) begin
      errors++; $display("FAIL busy t=%0t got %b exp %b", $time, busy, e_busy);
    end
    if (pkt_count !== e_pkt) begin
      errors++; $display("FAIL pkt_count t=%0t got %0d exp %0d", $time, pkt_count, e_pkt);
    end
    if (e_valid || !rst_n) begin
      checks += 2;
      if (m_tdata !== e_data) begin
        errors++; $display("FAIL tdata t=%0t got %h exp %h", $time, m_tdata, e_data);
      end
      if (m_tlast !== e_last) begin
        errors++; $display("FAIL tlast t=%0t got %b exp %b", $time, m_tlast, e_last);
      end
    end
    s_ren   = fifo_r_en;
    s_valid = m_tvalid;
    if (rst_n) begin
      if (fifo_r_en) dut_pops++;
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (m_tready && exp_q.size() > 0) begin
        if (exp_q[0][DW]) pkts++;
        void'(exp_q.pop_front());
      end
      if (e_ren) begin
        w = fifo_q.pop_front();
        exp_q.push_back({TL && (pos == PL - 1), w});
        pos = (pos + 1) % PL;
      end
      case (mode)
        M_IDLE:  if (rd_enable) mode = M_RUN;
        M_RUN:   if (!rd_enable) mode = (TL && pos != 0) ? M_DRAIN : M_IDLE;
        M_DRAIN: if (rd_enable) mode = M_RUN; else if (pos == 0) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset between edges, check outputs drop at once, then release it.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_r_en, m_tvalid, m_tlast, busy} !== 4'b0 || m_tdata !== '0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset got r_en=%b tvalid=%b tlast=%b busy=%b tdata=%h pkt=%0d exp all 0",
               fifo_r_en, m_tvalid, m_tlast, busy, m_tdata, pkt_count);
    end
    fifo_q.delete();
    cycle();
    rst_n = 1'b1;
  endtask

  // Check the words handed over in got_q against base+i with tlast every PL beats.
  task automatic check_seq(input string name, input int n, input logic [DW-1:0] base);
    logic e_last;
    checks++;
    if (got_q.size() != n) begin
      errors++; $display("FAIL %s_count got %0d exp %0d", name, got_q.size(), n);
    end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      e_last = TL && (i % PL == PL - 1);
      checks++;
      if (got_q[i] !== {e_last, base + DW'(i)}) begin
        errors++;
        $display("FAIL %s_beat%0d got %h/%b exp %h/%b", name, i,
                 got_q[i][DW-1:0], got_q[i][DW], base + DW'(i), e_last);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_enable = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(32'hA0 + i));
    run(4);
    fifo_q.delete();
    rd_enable = 1'b0;
    rst_n = 1'b1;
    run(2);
  endtask

  task automatic test_full_rate();
    int first_ren, first_valid, first_hs, last_hs, cyc;
    first_ren = -1; first_valid = -1; first_hs = -1; last_hs = -1;
    got_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h10 + i));
    rd_enable = 1'b1; m_tready = 1'b1;
    for (cyc = 0; cyc < 14; cyc++) begin
      cycle();
      if (s_ren && first_ren < 0) first_ren = cyc;
      if (s_valid && first_valid < 0) first_valid = cyc;
      if (s_valid) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
    end
    checks += 2;
    if (first_valid != first_ren + 1) begin
      errors++; $display("FAIL full_latency got valid@%0d exp %0d", first_valid, first_ren + 1);
    end
    if (last_hs - first_hs != 7) begin
      errors++; $display("FAIL full_b2b got span %0d exp 7", last_hs - first_hs);
    end
    check_seq("full", 8, DW'(32'h10));
    checks++;
    if (pkt_count !== (TL ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL full_pkts got %0d exp %0d", pkt_count, TL ? 2 : 0);
    end
    rd_enable = 1'b0;
    run(3);
  endtask

  task automatic test_backpressure();
    got_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(32'h20 + i));
    rd_enable = 1'b1;
    for (int i = 0; i < 36; i++) begin
      m_tready = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    check_seq("bp", 8, DW'(32'h20));
    rd_enable = 1'b0; m_tready = 1'b1;
    run(3);
  endtask

  // rd_enable drops right after the edge that took the 2nd word; that cycle still pops.
  task automatic test_stop();
    int cyc;
    got_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    dut_pops = 0; rd_enable = 1'b1; m_tready = 1'b1;
    for (cyc = 0; cyc < 20 && dut_pops < 2; cyc++) cycle();
    checks++;
    if (dut_pops != 2) begin
      errors++; $display("FAIL stop_reach got %0d pops exp 2", dut_pops);
    end
    rd_enable = 1'b0;
    run(12);
    checks += 3;
    if (dut_pops != (TL ? 4 : 3)) begin
      errors++; $display("FAIL stop_pops got %0d exp %0d", dut_pops, TL ? 4 : 3);
    end
    if (got_q.size() != dut_pops) begin
      errors++; $display("FAIL stop_delivered got %0d exp %0d", got_q.size(), dut_pops);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stop_busy got %b exp 0", busy);
    end
    fifo_q.delete();
  endtask

  task automatic test_empty_gap();
    int gap;
    gap = 0;
    got_q.delete();
    fifo_q.push_back(DW'(32'h40)); fifo_q.push_back(DW'(32'h41));
    rd_enable = 1'b1; m_tready = 1'b1;
    run(2);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (!s_valid) gap++;
    end
    fifo_q.push_back(DW'(32'h42)); fifo_q.push_back(DW'(32'h43));
    run(8);
    checks++;
    if (gap == 0) begin
      errors++; $display("FAIL gap_tvalid got 0 idle cycles exp >0");
    end
    check_seq("gap", 4, DW'(32'h40));
    rd_enable = 1'b0;
    run(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rd_enable = ($urandom_range(0, 7) != 0);
      m_tready  = $urandom_range(0, 1);
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) fifo_q.push_back($urandom);
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    pulse_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back($urandom);
    dut_pops = 0; rd_enable = 1'b1; m_tready = 1'b1;
    for (cyc = 0; cyc < 20 && dut_pops < 2; cyc++) cycle();
    checks++;
    if (dut_pops != 2) begin
      errors++; $display("FAIL rmid_reach got %0d pops exp 2", dut_pops);
    end
    pulse_reset();
    got_q.delete();
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(32'h60 + i));
    run(10);
    check_seq("rmid", 4, DW'(32'h60));
    checks++;
    if (pkt_count !== (TL ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL rmid_pkts got %0d exp %0d", pkt_count, TL ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_stop();
    test_empty_gap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
